// File: rtl/operand_fetch.sv
// operand_fetch: issue stage feeding register_file reads, with writeback bypass and a stall-holding output register
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready               upstream instruction handshake
//   in_rs0, in_rs1, in_use          source addresses and per-operand use flags
//   in_payload                      opaque payload carried with the operands
//   rf_read_en, rf_raddr_0/1        register_file read request
//   rf_rdata_0/1                    register_file combinational read data
//   wb_valid, wb_addr, wb_data      mirror of the register_file write port
//   out_valid/out_ready             downstream handshake to execute
//   out_op0, out_op1, out_payload   held operands and payload
module operand_fetch #(
   parameter int ADDR_W    = 6,
   parameter int DATA_W    = 32,
   parameter int PAYLOAD_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ADDR_W-1:0]    in_rs0,
   input  logic [ADDR_W-1:0]    in_rs1,
   input  logic [1:0]           in_use,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic [1:0]           rf_read_en,
   output logic [ADDR_W-1:0]    rf_raddr_0,
   output logic [ADDR_W-1:0]    rf_raddr_1,
   input  logic [DATA_W-1:0]    rf_rdata_0,
   input  logic [DATA_W-1:0]    rf_rdata_1,
   input  logic                 wb_valid,
   input  logic [ADDR_W-1:0]    wb_addr,
   input  logic [DATA_W-1:0]    wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_op0,
   output logic [DATA_W-1:0]    out_op1,
   output logic [PAYLOAD_W-1:0] out_payload
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] held_rs0, held_rs1;
   logic [1:0] held_use;
   logic accept, hold;
   assign rf_raddr_0 = in_rs0;
   assign rf_raddr_1 = in_rs1;
   assign out_valid  = state == FULL;
   always_comb begin
      in_ready   = !reset && (state == EMPTY || out_ready);
      accept     = in_valid && in_ready;
      hold       = state == FULL && !out_ready;
      rf_read_en = accept ? in_use : 2'b00;
      state_nxt  = (accept || hold) ? FULL : EMPTY;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= EMPTY;
      else state <= state_nxt;
   // The RF write lands on the same edge as the capture, so the RF read returns stale
   // data; forward wb_data on an address match. While stalled, keep tracking writes.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         out_op0     <= '0;
         out_op1     <= '0;
         out_payload <= '0;
         held_rs0    <= '0;
         held_rs1    <= '0;
         held_use    <= '0;
      end else if (accept) begin
         out_op0     <= !in_use[0] ? '0 : (wb_valid && wb_addr == in_rs0) ? wb_data : rf_rdata_0;
         out_op1     <= !in_use[1] ? '0 : (wb_valid && wb_addr == in_rs1) ? wb_data : rf_rdata_1;
         out_payload <= in_payload;
         held_rs0    <= in_rs0;
         held_rs1    <= in_rs1;
         held_use    <= in_use;
      end else if (hold) begin
         out_op0 <= (held_use[0] && wb_valid && wb_addr == held_rs0) ? wb_data : out_op0;
         out_op1 <= (held_use[1] && wb_valid && wb_addr == held_rs1) ? wb_data : out_op1;
      end
endmodule
